// File: rtl/instruction_sequencer.sv
// Instruction sequencer: buffers a machine-code program received over a
// valid/ready load stream, then replays it one word per issue slot on
// current_instruction after a start pulse, stopping at an all-zero word or
// at the end of the loaded program.
module instruction_sequencer #(
    parameter int INSTRUCTION_WIDTH = 32,
    parameter int DEPTH             = 1024,
    parameter int ADDRESS_WIDTH     = 10,
    parameter int ISSUE_INTERVAL    = 1
) (
    input  logic                         clock_in,
    input  logic                         reset_n_in,
    input  logic                         load_valid_in,
    output logic                         load_ready_out,
    input  logic [INSTRUCTION_WIDTH-1:0] load_data_in,
    input  logic                         load_last_in,
    input  logic                         start_in,
    output logic [INSTRUCTION_WIDTH-1:0] current_instruction,
    output logic                         instruction_valid_out,
    output logic [ADDRESS_WIDTH-1:0]     program_counter_out,
    output logic [ADDRESS_WIDTH:0]       program_length_out,
    output logic                         busy_out,
    output logic                         done_out,
    output logic                         overflow_error_out
);

    localparam int AW1    = ADDRESS_WIDTH + 1;
    localparam int HOLD_W = (ISSUE_INTERVAL > 1) ? $clog2(ISSUE_INTERVAL) : 1;
    localparam logic [AW1-1:0]    DEPTH_L   = AW1'(DEPTH);
    localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(ISSUE_INTERVAL - 1);

    typedef enum logic [1:0] {IDLE, LOAD, RUN, DONE} state_t;
    state_t state, next_state;

    logic [INSTRUCTION_WIDTH-1:0] mem [DEPTH];
    logic [INSTRUCTION_WIDTH-1:0] read_data;
    logic [ADDRESS_WIDTH-1:0]     fetch_addr;
    logic [AW1-1:0]               write_ptr, write_ptr_next;
    logic [HOLD_W-1:0]            hold_count;

    logic idle_like, accept_first, accept_word, drop_word, start_run;
    logic advance, last_done, zero_stop, issue;
    logic mem_write, mem_read, ready_next;
    logic [ADDRESS_WIDTH-1:0] write_addr, read_addr;

    // Decode the events of this cycle: load handshakes, start, and issue-slot boundaries.
    always_comb begin
        idle_like    = (state == IDLE) || (state == DONE);
        accept_first = idle_like && load_valid_in && load_ready_out;
        accept_word  = (state == LOAD) && load_valid_in && (write_ptr < DEPTH_L);
        drop_word    = (state == LOAD) && load_valid_in && (write_ptr >= DEPTH_L);
        // A simultaneous load request always wins over start.
        start_run    = idle_like && start_in && !load_valid_in && (program_length_out != '0);
        // read_data always holds the word at fetch_addr; it moves to the output
        // on the first slot of a run and whenever the current word's hold ends.
        advance      = (state == RUN) && (!instruction_valid_out || (hold_count == HOLD_LAST));
        last_done    = advance && instruction_valid_out &&
                       ((AW1'(program_counter_out) + AW1'(1)) == program_length_out);
        zero_stop    = advance && !last_done && (read_data == '0);
        issue        = advance && !last_done && !zero_stop;

        write_ptr_next = write_ptr;
        if (accept_first) begin
            write_ptr_next = AW1'(1);
        end else if (accept_word) begin
            write_ptr_next = write_ptr + AW1'(1);
        end

        mem_write  = accept_first || accept_word;
        write_addr = accept_first ? '0 : write_ptr[ADDRESS_WIDTH-1:0];
        // Read ahead so the next word is ready the moment the current one retires.
        mem_read   = start_run || issue;
        read_addr  = start_run ? '0 : (fetch_addr + ADDRESS_WIDTH'(1));
    end

    // Next-state logic for the IDLE/LOAD/RUN/DONE controller.
    always_comb begin
        next_state = state;
        unique case (state)
            IDLE, DONE: begin
                if (accept_first) begin
                    next_state = load_last_in ? IDLE : LOAD;
                end else if (start_in && !load_valid_in) begin
                    next_state = (program_length_out != '0) ? RUN : DONE;
                end
            end
            LOAD: begin
                if (load_valid_in && load_last_in) begin
                    next_state = IDLE;
                end
            end
            RUN: begin
                if (last_done || zero_stop) begin
                    next_state = DONE;
                end
            end
            default: next_state = IDLE;
        endcase
        ready_next = (next_state == IDLE) || (next_state == DONE) ||
                     ((next_state == LOAD) && (write_ptr_next < DEPTH_L));
    end

    // State register.
    always_ff @(posedge clock_in or negedge reset_n_in) begin
        if (!reset_n_in) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    // Control and output registers: load bookkeeping, issue slot timing, status flags.
    always_ff @(posedge clock_in or negedge reset_n_in) begin
        if (!reset_n_in) begin
            write_ptr             <= '0;
            fetch_addr            <= '0;
            hold_count            <= '0;
            load_ready_out        <= 1'b0;
            current_instruction   <= '0;
            instruction_valid_out <= 1'b0;
            program_counter_out   <= '0;
            program_length_out    <= '0;
            busy_out              <= 1'b0;
            done_out              <= 1'b0;
            overflow_error_out    <= 1'b0;
        end else begin
            write_ptr      <= write_ptr_next;
            load_ready_out <= ready_next;
            busy_out       <= (next_state == LOAD) || (next_state == RUN);
            done_out       <= (next_state == DONE);

            if (accept_first) begin
                overflow_error_out <= 1'b0;
                if (load_last_in) begin
                    program_length_out <= AW1'(1);
                end
            end
            if (accept_word && load_last_in) begin
                program_length_out <= write_ptr + AW1'(1);
            end
            if (drop_word) begin
                overflow_error_out <= 1'b1;
                if (load_last_in) begin
                    program_length_out <= DEPTH_L;
                end
            end

            if (start_run) begin
                fetch_addr <= '0;
            end
            if (issue) begin
                current_instruction   <= read_data;
                instruction_valid_out <= 1'b1;
                program_counter_out   <= fetch_addr;
                fetch_addr            <= fetch_addr + ADDRESS_WIDTH'(1);
                hold_count            <= '0;
            end else if (advance) begin
                // Run ends: program_counter_out keeps the last issued address.
                current_instruction   <= '0;
                instruction_valid_out <= 1'b0;
            end else if (state == RUN) begin
                hold_count <= hold_count + HOLD_W'(1);
            end
        end
    end

    // Instruction memory: synchronous write from the load stream, synchronous read-ahead.
    always_ff @(posedge clock_in) begin
        if (mem_write) begin
            mem[write_addr] <= load_data_in;
        end
        if (mem_read) begin
            read_data <= mem[read_addr];
        end
    end

endmodule

// File: tb/tb_instruction_sequencer.sv
// Testbench for instruction_sequencer: two instances (issue interval 1 and 3)
// share one stimulus stream and are compared against a program-level model.
module tb_instruction_sequencer;

    localparam int W  = 32;
    localparam int D  = 16;
    localparam int AW = 4;

    typedef logic [63:0] obs_t;

    logic          clock_in = 1'b0;
    logic          reset_n_in;
    logic          load_valid_in, load_last_in, start_in;
    logic [W-1:0]  load_data_in;

    logic          rdy1, vld1, busy1, done1, ovf1;
    logic [W-1:0]  cur1;
    logic [AW-1:0] pc1;
    logic [AW:0]   len1;
    logic          rdy3, vld3, busy3, done3, ovf3;
    logic [W-1:0]  cur3;
    logic [AW-1:0] pc3;
    logic [AW:0]   len3;

    instruction_sequencer #(.INSTRUCTION_WIDTH(W), .DEPTH(D), .ADDRESS_WIDTH(AW), .ISSUE_INTERVAL(1)) dut1 (
        .clock_in(clock_in), .reset_n_in(reset_n_in),
        .load_valid_in(load_valid_in), .load_ready_out(rdy1),
        .load_data_in(load_data_in), .load_last_in(load_last_in), .start_in(start_in),
        .current_instruction(cur1), .instruction_valid_out(vld1),
        .program_counter_out(pc1), .program_length_out(len1),
        .busy_out(busy1), .done_out(done1), .overflow_error_out(ovf1)
    );

    instruction_sequencer #(.INSTRUCTION_WIDTH(W), .DEPTH(D), .ADDRESS_WIDTH(AW), .ISSUE_INTERVAL(3)) dut3 (
        .clock_in(clock_in), .reset_n_in(reset_n_in),
        .load_valid_in(load_valid_in), .load_ready_out(rdy3),
        .load_data_in(load_data_in), .load_last_in(load_last_in), .start_in(start_in),
        .current_instruction(cur3), .instruction_valid_out(vld3),
        .program_counter_out(pc3), .program_length_out(len3),
        .busy_out(busy3), .done_out(done3), .overflow_error_out(ovf3)
    );

    always #5 clock_in = ~clock_in;

    int n_tests = 0;
    int n_fail  = 0;

    // Reference model: the stored program and its status, at program level.
    logic [W-1:0] prog[$];
    logic [W-1:0] m_mem [D];
    int           m_len = 0;
    logic         m_ovf = 1'b0;

    obs_t M_RUN, M_PC, M_RDY, M_LEN, M_LOAD, M_ALL;

    typedef struct {
        int           n;
        logic [W-1:0] w [4];
        int           exp_issued;
        int           exp_len;
    } vec_t;
    vec_t tbl [6];

    function automatic obs_t mk(input logic rdy, input logic ovf, input int len,
                                input logic busy, input logic done, input logic vld,
                                input logic [W-1:0] cur, input int pc);
        obs_t o;
        o        = '0;
        o[45]    = rdy;
        o[44]    = ovf;
        o[43:39] = len[4:0];
        o[38]    = busy;
        o[37]    = done;
        o[36]    = vld;
        o[35:4]  = cur;
        o[3:0]   = pc[3:0];
        return o;
    endfunction

    function automatic obs_t observe(input int iv);
        if (iv == 1) return mk(rdy1, ovf1, int'(len1), busy1, done1, vld1, cur1, int'(pc1));
        return mk(rdy3, ovf3, int'(len3), busy3, done3, vld3, cur3, int'(pc3));
    endfunction

    task automatic check(input string name, input obs_t got, input obs_t exp, input obs_t mask);
        n_tests++;
        if ((got & mask) !== (exp & mask)) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h (mask %h)", name, got & mask, exp & mask, mask);
        end
    endtask

    task automatic tick();
        @(negedge clock_in);
    endtask

    task automatic set_vec(input int idx, input int n, input logic [W-1:0] w0, input logic [W-1:0] w1,
                           input logic [W-1:0] w2, input logic [W-1:0] w3, input int iss, input int len);
        tbl[idx].n = n;
        tbl[idx].w[0] = w0; tbl[idx].w[1] = w1; tbl[idx].w[2] = w2; tbl[idx].w[3] = w3;
        tbl[idx].exp_issued = iss;
        tbl[idx].exp_len = len;
    endtask

    // Model of a completed load of prog: words beyond DEPTH are dropped.
    task automatic model_load();
        m_len = (prog.size() > D) ? D : prog.size();
        for (int i = 0; i < m_len; i++) m_mem[i] = prog[i];
        m_ovf = (prog.size() > D);
    endtask

    task automatic load_prog(input bit gaps, input bit poke_start, input bit check_ready);
        for (int i = 0; i < prog.size(); i++) begin
            if (gaps) begin
                int g;
                g = $urandom_range(0, 2);
                for (int k = 0; k < g; k++) begin
                    load_valid_in = 1'b0;
                    load_last_in  = 1'b0;
                    start_in      = poke_start && (i > 0);
                    tick();
                end
            end
            load_valid_in = 1'b1;
            load_data_in  = prog[i];
            load_last_in  = (i == prog.size() - 1);
            start_in      = poke_start;
            if (check_ready)
                check($sformatf("load_ready_word%0d", i), observe(1), mk(i < D, 0, 0, 0, 0, 0, '0, 0), M_RDY);
            tick();
        end
        load_valid_in = 1'b0;
        load_last_in  = 1'b0;
        start_in      = 1'b0;
        load_data_in  = '0;
        model_load();
        tick();
    endtask

    task automatic post_load_check(input string tag);
        check({tag, "_load_iv1"}, observe(1), mk(1, m_ovf, m_len, 0, 0, 0, '0, 0), M_LOAD);
        check({tag, "_load_iv3"}, observe(3), mk(1, m_ovf, m_len, 0, 0, 0, '0, 0), M_LOAD);
    endtask

    // Pulse start and compare every cycle of both instances against the
    // expected issue trace: one busy cycle, each issued word held for its
    // interval, then DONE.
    task automatic run_check(input string tag, input bit poke, output int issued);
        int n_iss;
        int limit;
        n_iss = 0;
        while (n_iss < m_len && m_mem[n_iss] != '0) n_iss++;
        limit  = n_iss * 3 + 4;
        issued = 0;
        start_in = 1'b1;
        tick();
        start_in = 1'b0;
        for (int c = 1; c <= limit; c++) begin
            for (int k = 0; k < 2; k++) begin
                int   iv;
                obs_t got, exp, mask;
                iv   = (k == 0) ? 1 : 3;
                got  = observe(iv);
                mask = M_RUN;
                if (m_len == 0) begin
                    exp = mk(0, 0, 0, 0, 1, 0, '0, 0);
                end else if (c == 1) begin
                    exp = mk(0, 0, 0, 1, 0, 0, '0, 0);
                end else if (c - 2 < n_iss * iv) begin
                    exp  = mk(0, 0, 0, 1, 0, 1, m_mem[(c - 2) / iv], (c - 2) / iv);
                    mask = mask | M_PC;
                end else begin
                    exp = mk(0, 0, 0, 0, 1, 0, '0, (n_iss > 0) ? n_iss - 1 : 0);
                    if (n_iss > 0) mask = mask | M_PC;
                end
                check($sformatf("%s_iv%0d_cyc%0d", tag, iv, c), got, exp, mask);
                if (iv == 1 && got[36]) issued++;
            end
            start_in = (poke && c == 2 && n_iss >= 1);
            tick();
        end
        start_in = 1'b0;
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached, got no finish, expected finish");
        $fatal(1);
    end

    initial begin
        int iss;
        M_RUN  = mk(0, 0, 0, 1, 1, 1, '1, 0);
        M_PC   = mk(0, 0, 0, 0, 0, 0, '0, 15);
        M_RDY  = mk(1, 0, 0, 0, 0, 0, '0, 0);
        M_LEN  = mk(0, 0, 31, 0, 0, 0, '0, 0);
        M_LOAD = mk(1, 1, 31, 1, 1, 1, '0, 0);
        M_ALL  = mk(1, 1, 31, 1, 1, 1, '1, 15);

        set_vec(0, 3, 32'h11, 32'h22, 32'h33, 32'h0, 3, 3);
        set_vec(1, 3, 32'hA,  32'h0,  32'hB,  32'h0, 1, 3);
        set_vec(2, 2, 32'h0,  32'h5,  32'h0,  32'h0, 0, 2);
        set_vec(3, 1, 32'h7,  32'h0,  32'h0,  32'h0, 1, 1);
        set_vec(4, 4, 32'h1,  32'h2,  32'h3,  32'h4, 4, 4);
        set_vec(5, 2, 32'h5A, 32'hA5, 32'h0,  32'h0, 2, 2);

        reset_n_in    = 1'b0;
        load_valid_in = 1'b0;
        load_last_in  = 1'b0;
        start_in      = 1'b0;
        load_data_in  = '0;
        tick();
        tick();
        check("reset_iv1", observe(1), '0, M_ALL);
        check("reset_iv3", observe(3), '0, M_ALL);
        reset_n_in = 1'b1;
        tick();
        check("idle_ready_iv1", observe(1), mk(1, 0, 0, 0, 0, 0, '0, 0), M_LOAD);

        // Table-driven programs.
        for (int t = 0; t < 6; t++) begin
            prog.delete();
            for (int i = 0; i < tbl[t].n; i++) prog.push_back(tbl[t].w[i]);
            load_prog(0, 0, 0);
            check($sformatf("tbl%0d_length", t), observe(1), mk(0, 0, tbl[t].exp_len, 0, 0, 0, '0, 0), M_LEN);
            post_load_check($sformatf("tbl%0d", t));
            run_check($sformatf("tbl%0d", t), (t == 4), iss);
            check($sformatf("tbl%0d_issued", t), obs_t'(iss), obs_t'(tbl[t].exp_issued), '1);
        end

        // Overfill: DEPTH+2 words with gaps, last on the final (dropped) word.
        prog.delete();
        for (int i = 0; i < D + 2; i++) prog.push_back($urandom | 32'h1);
        load_prog(1, 0, 1);
        check("overflow_flag", observe(1), mk(0, 1, D, 0, 0, 0, '0, 0), M_LEN | mk(0, 1, 0, 0, 0, 0, '0, 0));
        post_load_check("overflow");
        run_check("overflow", 0, iss);
        check("overflow_issued", obs_t'(iss), obs_t'(D), '1);

        // Randomized programs with load gaps, start pokes during load and run.
        for (int it = 0; it < 8; it++) begin
            int n;
            n = $urandom_range(1, D);
            prog.delete();
            for (int i = 0; i < n; i++) prog.push_back(($urandom_range(0, 9) == 0) ? 32'h0 : ($urandom | 32'h1));
            load_prog(1, it[0], 0);
            post_load_check($sformatf("rnd%0d", it));
            run_check($sformatf("rnd%0d", it), !it[0], iss);
            if (it % 3 == 0) run_check($sformatf("rnd%0d_restart", it), 0, iss);
        end

        // In DONE: start together with load -> the load wins and no issue happens.
        load_valid_in = 1'b1;
        load_data_in  = 32'h55;
        load_last_in  = 1'b0;
        start_in      = 1'b1;
        tick();
        load_data_in  = 32'h66;
        load_last_in  = 1'b1;
        start_in      = 1'b0;
        check("start_load_iv1", observe(1), mk(0, 0, 0, 1, 0, 0, '0, 0), M_RUN);
        check("start_load_iv3", observe(3), mk(0, 0, 0, 1, 0, 0, '0, 0), M_RUN);
        tick();
        load_valid_in = 1'b0;
        load_last_in  = 1'b0;
        load_data_in  = '0;
        prog.delete();
        prog.push_back(32'h55);
        prog.push_back(32'h66);
        model_load();
        tick();
        post_load_check("start_load");
        run_check("start_load", 0, iss);
        check("start_load_issued", obs_t'(iss), obs_t'(2), '1);

        // Asynchronous reset in the middle of a run.
        prog.delete();
        for (int i = 0; i < 8; i++) prog.push_back(32'h100 + i);
        load_prog(0, 0, 0);
        start_in = 1'b1;
        tick();
        start_in = 1'b0;
        tick();
        tick();
        #2;
        reset_n_in = 1'b0;
        #1;
        check("async_reset_iv1", observe(1), '0, M_ALL);
        check("async_reset_iv3", observe(3), '0, M_ALL);
        tick();
        reset_n_in = 1'b1;
        m_len = 0;
        m_ovf = 1'b0;
        tick();
        check("post_reset_iv1", observe(1), mk(1, 0, 0, 0, 0, 0, '0, 0), M_LOAD);
        run_check("empty_start", 0, iss);
        check("empty_start_issued", obs_t'(iss), obs_t'(0), '1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/instruction_sequencer.md
Name: instruction_sequencer

Overview:
Hardware replacement for the bench-side instruction feeder. It accepts a machine-code program over a valid/ready load stream and buffers it in an internal instruction memory. On start it drives `current_instruction` into `cpu` one word per issue slot. It stops at the first all-zero word or at the end of the loaded program, then reports completion.

Parameters:
INSTRUCTION_WIDTH, 32, width of one machine-code word
DEPTH, 1024, instruction memory entries (power of two)
ADDRESS_WIDTH, 10, log2(DEPTH)
ISSUE_INTERVAL, 1, clock cycles each instruction is held on `current_instruction` (>=1)

Ports:
clock_in  input  1  single clock, rising edge
reset_n_in  input  1  asynchronous, active-low reset
load_valid_in  input  1  load word present
load_ready_out  output  1  sequencer can accept a load word
load_data_in  input  INSTRUCTION_WIDTH  machine-code word to store
load_last_in  input  1  marks final word of the program
start_in  input  1  one-cycle pulse: begin issuing from address 0
current_instruction  output  INSTRUCTION_WIDTH  instruction to `cpu`, all-zero when not issuing
instruction_valid_out  output  1  `current_instruction` holds a real issued word
program_counter_out  output  ADDRESS_WIDTH  address of the word currently on `current_instruction`
program_length_out  output  ADDRESS_WIDTH+1  number of words stored by the last load
busy_out  output  1  high in LOAD or RUN
done_out  output  1  high in DONE
overflow_error_out  output  1  sticky: a load word arrived while memory was full

Behaviour:
- Interface: one clock, `clock_in`. Reset is asynchronous and active-low on `reset_n_in`.
- Reset values:
  - state=IDLE
  - all outputs 0, including `current_instruction`, `program_length_out` and `overflow_error_out`
  - write pointer 0
  - memory contents are not reset
- States: IDLE, LOAD, RUN, DONE.
- IDLE:
  - `load_ready_out`=1.
  - On `load_valid_in`: write the word at address 0, set write pointer to 1, clear `overflow_error_out`, go to LOAD. If `load_last_in` is also set, go straight to IDLE with length 1.
  - On `start_in` with `program_length_out`>0: go to RUN. If length is 0, `start_in` goes straight to DONE.
- LOAD:
  - `load_ready_out` = (write pointer < DEPTH).
  - Each valid&ready cycle writes `mem[wp]` and increments `wp`.
  - When `load_last_in` is accepted: `program_length_out` = `wp`+1, return to IDLE.
  - When `load_valid_in` is high while full: set `overflow_error_out` and drop the word.
    - If that word carries `load_last_in`, `program_length_out`=DEPTH and return to IDLE.
  - `start_in` is ignored in LOAD.
- RUN:
  - Memory read is synchronous. The word at address n appears on `current_instruction` one cycle after the read is issued.
  - The first word appears 2 cycles after the `start_in` pulse.
  - Each word is held for exactly ISSUE_INTERVAL cycles with `instruction_valid_out`=1 and `program_counter_out`=n.
  - The next word follows with no gap.
- Termination in RUN:
  - If a fetched word is 32'h00000000, it is not issued. `current_instruction` stays 0, `instruction_valid_out`=0, go to DONE.
  - After the word at address `program_length_out`-1 completes its interval, go to DONE.
  - The address counter does not wrap. Address DEPTH-1 is the last possible issue.
- DONE:
  - `done_out`=1, `current_instruction`=0, `instruction_valid_out`=0.
  - `program_counter_out` holds the last issued address.
  - `start_in` restarts RUN from address 0 using the same program.
  - `load_valid_in` begins a new LOAD exactly as from IDLE.
- Simultaneous events:
  - `start_in` together with `load_valid_in` in IDLE or DONE: load wins and start is dropped.
  - `start_in` during RUN is ignored.
- Reset mid-operation: immediate return to reset values. The stored program length is lost; memory contents are retained but unusable until reloaded.
- `busy_out` and `done_out` are registered state decodes and are never high together.

Test Plan:
- Load 3 words {0x11, 0x22, 0x33} (last on 0x33), pulse start → 0x11, 0x22, 0x33 each valid 1 cycle at PC 0, 1, 2; first word 2 cycles after start; then `done_out`=1 and `current_instruction`=0.
- Load {0xA, 0x0, 0xB}, start → only 0xA issued; `done_out` asserts the cycle after 0x0 is fetched; 0xB never valid.
- ISSUE_INTERVAL=3, 2-word program → each word held 3 cycles; `done_out` after cycle 6 of issue.
- Load with random `load_valid_in` gaps over DEPTH+2 words, last on the final word → `load_ready_out` low once full; `overflow_error_out`=1; `program_length_out`=DEPTH; issue sequence matches the first DEPTH words.
- Assert `reset_n_in`=0 mid-RUN, asynchronously between edges → outputs 0 immediately; `start_in` after release with length 0 → DONE with no instruction issued.
- In DONE, pulse `start_in` together with `load_valid_in` → new LOAD begins, no issue; a second `start_in` after load completes issues the new program.
